// File: rtl/bus_pkg.sv
// Shared types and default address map for the data-side bus bridge.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_N_SLV  = 4;

    // Default map: data RAM in slot 0, three MMIO windows above it.
    localparam logic [DEF_ADDR_W-1:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [DEF_ADDR_W-1:0] RAM_MASK   = 32'hFFFF_0000;
    localparam logic [DEF_ADDR_W-1:0] MMIO0_BASE = 32'h1000_0000;
    localparam logic [DEF_ADDR_W-1:0] MMIO1_BASE = 32'h2000_0000;
    localparam logic [DEF_ADDR_W-1:0] MMIO2_BASE = 32'h3000_0000;
    localparam logic [DEF_ADDR_W-1:0] MMIO_MASK  = 32'hFFFF_0000;

    localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_SLV_BASE =
        {MMIO2_BASE, MMIO1_BASE, MMIO0_BASE, RAM_BASE};
    localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_SLV_MASK =
        {MMIO_MASK, MMIO_MASK, MMIO_MASK, RAM_MASK};

    function automatic int unsigned strb_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/addr_decoder.sv
// Combinational priority decode of an access address against per-slave windows.
module addr_decoder
    import bus_pkg::*;
#(
    parameter int unsigned N_SLV  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 2,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit_c,
    output logic [IDX_W-1:0]  idx_c
);

    // Scan from the top slot down so the lowest matching index is left standing.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_c = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Data-side bridge from the core memory port to N windowed slaves with stall handshake.
// Optional WAIT watchdog enabled by defining BUS_TIMEOUT_EN.
module dmem_bus_bridge
    import bus_pkg::*;
#(
    parameter int unsigned N_SLV   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          m_req,
    input  logic [strb_width(DATA_W)-1:0] m_wstrb,
    input  logic [ADDR_W-1:0]             m_addr,
    input  logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_stall,
    output logic                          m_err,
    output logic [N_SLV-1:0]              s_req,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [strb_width(DATA_W)-1:0] s_wstrb,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [N_SLV*DATA_W-1:0]       s_rdata,
    input  logic [N_SLV-1:0]              s_ack
);

    localparam int unsigned STRB_W = strb_width(DATA_W);
    localparam int unsigned IDX_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    state_t            state;
    logic [IDX_W-1:0]  sel;
    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              sel_ack;
    logic [DATA_W-1:0] sel_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wait_cnt;
`endif

    addr_decoder #(
        .N_SLV    (N_SLV),
        .ADDR_W   (ADDR_W),
        .IDX_W    (IDX_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_addr_decoder (
        .addr  (m_addr),
        .hit_c (dec_hit),
        .idx_c (dec_idx)
    );

    // Only the latched slave's ack and data are visible to the FSM.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(N_SLV); i++) begin
            if (sel == IDX_W'(i)) begin
                sel_ack   = s_ack[i];
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stall must drop in the same cycle the core sees DONE, so it is decoded from state.
    assign m_stall = ((state == IDLE) && m_req) || (state == WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sel     <= '0;
            s_req   <= '0;
            s_addr  <= '0;
            s_wstrb <= '0;
            s_wdata <= '0;
            m_rdata <= '0;
            m_err   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            s_req <= '0;
            m_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_req) begin
                        if (dec_hit) begin
                            sel     <= dec_idx;
                            s_addr  <= m_addr;
                            s_wstrb <= m_wstrb;
                            s_wdata <= m_wdata;
                            s_req   <= N_SLV'(1) << dec_idx;
                            state   <= WAIT;
`ifdef BUS_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end else begin
                            // Unmapped: complete with an error, nothing reaches a slave.
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                            state   <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (sel_ack) begin
                        m_rdata <= (s_wstrb == STRB_W'(0)) ? sel_rdata : '0;
                        state   <= DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: directed table, random traffic, reset and no-ack cases.
module tb_dmem_bus_bridge;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    // Slot 3 (0x10xx_xxxx) overlaps slot 1 (0x1000_xxxx) so priority is exercised.
    localparam logic [N*AW-1:0] BASE = {32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [N*AW-1:0] MASK = {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    localparam logic [N*DW-1:0] RD   = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'h1234_5678};

    typedef struct {
        logic [31:0]  addr;
        logic [3:0]   wstrb;
        logic [31:0]  wdata;
        int           lat;
        logic [3:0]   spur;
        logic [127:0] rd_all;
        logic [3:0]   exp_sreq;
        int           exp_stall;
        logic         exp_err;
        logic [31:0]  exp_rdata;
    } vec_t;

    logic            clk;
    logic            reset;
    logic            m_req;
    logic [SW-1:0]   m_wstrb;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_stall;
    logic            m_err;
    logic [N-1:0]    s_req;
    logic [AW-1:0]   s_addr;
    logic [SW-1:0]   s_wstrb;
    logic [DW-1:0]   s_wdata;
    logic [N*DW-1:0] s_rdata;
    logic [N-1:0]    s_ack;

    int n_vec = 0;
    int n_err = 0;

    int       lat_cfg   = -1;
    logic [3:0] spur_mask = '0;
    int       pend      = 0;
    int       pcnt      = 0;
    int       pidx      = 0;

    dmem_bus_bridge #(
        .N_SLV    (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .SLV_BASE (BASE),
        .SLV_MASK (MASK),
        .TIMEOUT  (15)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_req   (m_req),
        .m_wstrb (m_wstrb),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_stall (m_stall),
        .m_err   (m_err),
        .s_req   (s_req),
        .s_addr  (s_addr),
        .s_wstrb (s_wstrb),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: acks the requested slave lat_cfg cycles after its s_req (0 = same cycle).
    always @(negedge clk) begin
        s_ack = '0;
        if (pend != 0) begin
            s_ack = s_ack | spur_mask;
            if (pcnt == 0) begin
                s_ack[pidx] = 1'b1;
                pend = 0;
            end else begin
                pcnt--;
            end
        end
        if (s_req != '0 && lat_cfg >= 0) begin
            for (int i = 0; i < 4; i++) if (s_req[i]) pidx = i;
            if (lat_cfg == 0) s_ack[pidx] = 1'b1;
            else begin
                pend = 1;
                pcnt = lat_cfg - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode: first window (lowest index) whose masked address equals its base.
    function automatic vec_t model(input vec_t v);
        logic [31:0] wb [4];
        logic [31:0] wm [4];
        vec_t r;
        int   hit = -1;
        wb = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000};
        wm = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000};
        r = v;
        for (int i = 0; i < 4; i++)
            if (hit < 0 && ((v.addr & wm[i]) == wb[i])) hit = i;
        if (hit < 0) begin
            r.exp_sreq  = 4'h0;
            r.exp_stall = 1;
            r.exp_err   = 1'b1;
            r.exp_rdata = 32'h0;
        end else begin
            r.exp_sreq  = 4'(1 << hit);
            r.exp_stall = 2 + v.lat;
            r.exp_err   = 1'b0;
            r.exp_rdata = (v.wstrb == 4'h0) ? v.rd_all[hit*32 +: 32] : 32'h0;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] wstrb,
                                input logic [31:0] wdata, input int lat, input logic [3:0] spur,
                                input logic [3:0] exp_sreq, input int exp_stall,
                                input logic exp_err, input logic [31:0] exp_rdata);
        vec_t v;
        v.addr = addr; v.wstrb = wstrb; v.wdata = wdata; v.lat = lat; v.spur = spur;
        v.rd_all = RD; v.exp_sreq = exp_sreq; v.exp_stall = exp_stall;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Issue one access (entered #1 after a posedge) and check the whole transaction.
    task automatic run_vec(input vec_t v, input string tag);
        int          stall_cnt = 0;
        int          pulses    = 0;
        int          errs      = 0;
        bit          done      = 0;
        logic [3:0]  sreq_seen = '0;
        logic [31:0] sa = '0;
        logic [31:0] sd = '0;
        logic [3:0]  ss = '0;
        s_rdata   = v.rd_all;
        lat_cfg   = v.lat;
        spur_mask = v.spur;
        m_req     = 1'b1;
        m_addr    = v.addr;
        m_wstrb   = v.wstrb;
        m_wdata   = v.wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (m_stall) stall_cnt++;
            if (m_err) errs++;
            if (s_req != '0) begin
                pulses++;
                sreq_seen = s_req;
                sa = s_addr; ss = s_wstrb; sd = s_wdata;
            end
            if (!m_stall) begin
                done = 1;
                chk({tag, " m_err"}, 32'(m_err), 32'(v.exp_err));
                chk({tag, " m_rdata"}, m_rdata, v.exp_rdata);
            end
            @(posedge clk);
            #1;
        end
        m_req = 1'b0;
        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " stall cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
        chk({tag, " err pulses"}, 32'(errs), 32'(v.exp_err));
        chk({tag, " s_req"}, 32'(sreq_seen), 32'(v.exp_sreq));
        chk({tag, " s_req pulses"}, 32'(pulses), (v.exp_sreq != 4'h0) ? 32'd1 : 32'd0);
        if (v.exp_sreq != 4'h0) begin
            chk({tag, " s_addr"}, sa, v.addr);
            chk({tag, " s_wstrb"}, 32'(ss), 32'(v.wstrb));
            chk({tag, " s_wdata"}, sd, v.wdata);
        end
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = mk(32'h0000_0010, 4'h0, 32'h0, 1, 4'h0, 4'b0001, 3, 1'b0, 32'h1234_5678);
        tbl[1] = mk(32'h2000_0100, 4'b0011, 32'hCAFE_F00D, 4, 4'h0, 4'b0100, 6, 1'b0, 32'h0);
        tbl[2] = mk(32'hF000_0000, 4'h0, 32'h0, 1, 4'h0, 4'b0000, 1, 1'b1, 32'h0);
        tbl[3] = mk(32'h1000_0040, 4'h0, 32'h0, 3, 4'b1000, 4'b0010, 5, 1'b0, 32'hBBBB_0001);
        tbl[4] = mk(32'h1050_0000, 4'h0, 32'h0, 0, 4'h0, 4'b1000, 2, 1'b0, 32'hDDDD_0003);
        tbl[5] = mk(32'h1000_0004, 4'h0, 32'h0, 2, 4'h0, 4'b0010, 4, 1'b0, 32'hBBBB_0001);
        tbl[6] = mk(32'h3000_0000, 4'hF, 32'h5555_AAAA, 1, 4'h0, 4'b0000, 1, 1'b1, 32'h0);

        reset = 1'b1; m_req = 1'b0; m_addr = '0; m_wstrb = '0; m_wdata = '0;
        s_rdata = '0; s_ack = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst s_req", 32'(s_req), 32'h0);
        chk("rst s_addr", s_addr, 32'h0);
        chk("rst s_wstrb", 32'(s_wstrb), 32'h0);
        chk("rst s_wdata", s_wdata, 32'h0);
        chk("rst m_rdata", m_rdata, 32'h0);
        chk("rst m_err", 32'(m_err), 32'h0);
        chk("rst m_stall idle", 32'(m_stall), 32'h0);
        m_req = 1'b1;
        #1;
        chk("rst m_stall req", 32'(m_stall), 32'h1);
        m_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed table, issued back-to-back.
        for (int k = 0; k < 7; k++) run_vec(tbl[k], $sformatf("tbl%0d", k));

        // Random traffic against the reference model.
        for (int k = 0; k < 60; k++) begin
            vec_t v;
            case ($urandom_range(0, 4))
                0:       v.addr = {16'h0000, 16'($urandom)};
                1:       v.addr = {16'h1000, 16'($urandom)};
                2:       v.addr = {16'h2000, 16'($urandom)};
                3:       v.addr = {8'h10, 24'($urandom)};
                default: v.addr = $urandom;
            endcase
            v.wstrb  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            v.wdata  = $urandom;
            v.lat    = int'($urandom_range(0, 5));
            v.spur   = 4'h0;
            v.rd_all = {$urandom, $urandom, $urandom, $urandom};
            run_vec(model(v), $sformatf("rnd%0d", k));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset while waiting on slave 0; its late ack must be ignored.
        lat_cfg = 3; spur_mask = 4'h0; s_rdata = RD;
        m_req = 1'b1; m_addr = 32'h0000_0010; m_wstrb = 4'h0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw s_req", 32'(s_req), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1; m_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rstw stall c%0d", c), 32'(m_stall), 32'h0);
            chk($sformatf("rstw err c%0d", c), 32'(m_err), 32'h0);
            chk($sformatf("rstw s_req c%0d", c), 32'(s_req), 32'h0);
            @(posedge clk); #1;
        end
        chk("rstw m_rdata", m_rdata, 32'h0);
        m_req = 1'b1;
        #2;
        chk("rstw stall follows req", 32'(m_stall), 32'h1);
        m_req = 1'b0;
        @(posedge clk); #1;
        run_vec(tbl[0], "rstw after");

        // Slave that never acks.
`ifdef BUS_TIMEOUT_EN
        run_vec(mk(32'h2000_0008, 4'h0, 32'h0, -1, 4'h0, 4'b0100, 16, 1'b1, 32'h0), "timeout");
        run_vec(tbl[5], "after timeout");
`else
        begin
            int held = 0;
            lat_cfg = -1;
            m_req = 1'b1; m_addr = 32'h2000_0008; m_wstrb = 4'h0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (m_stall) held++;
                @(posedge clk); #1;
            end
            chk("noack stall held", 32'(held), 32'd100);
            reset = 1'b1; m_req = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            run_vec(tbl[0], "after noack");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Parametrised data-side bus bridge between the processor core's memory port and N memory-mapped slaves (data RAM, MMIO peripherals). Decodes each core access against per-slave address windows, issues a one-cycle request to the selected slave, waits for its acknowledge, and holds the core with a stall until the access completes. Generalises the fixed single-RAM data path to multiple slaves with variable latency and error responses for unmapped addresses.

## Interface
- N_SLV, 4: number of slave channels (1..8)
- ADDR_W, 32: address width
- DATA_W, 32: data width; strobe width is DATA_W/8
- SLV_BASE, {N_SLV x ADDR_W}: packed base addresses, slot i at [i*ADDR_W +: ADDR_W]
- SLV_MASK, {N_SLV x ADDR_W}: packed masks; hit(i) = (m_addr & mask_i) == base_i
- TIMEOUT, 15: max WAIT cycles before error (only with BUS_TIMEOUT_EN)

- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- m_req  in  1  core access request, held stable while m_stall=1
- m_wstrb  in  DATA_W/8  byte write enables; all-zero = read
- m_addr  in  ADDR_W  access address
- m_wdata  in  DATA_W  write data
- m_rdata  out  DATA_W  read data, valid in DONE
- m_stall  out  1  holds core pipeline
- m_err  out  1  one-cycle error pulse in DONE
- s_req  out  N_SLV  one-hot, one-cycle request pulse
- s_addr  out  ADDR_W  registered address, shared
- s_wstrb  out  DATA_W/8  registered strobes, shared
- s_wdata  out  DATA_W  registered write data, shared
- s_rdata  in  N_SLV*DATA_W  per-slave read data
- s_ack  in  N_SLV  per-slave acknowledge, one pulse per request

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if m_req, decode; lowest index wins on overlapping windows. Hit: latch index, addr, wstrb, wdata; pulse s_req[sel] next cycle; go WAIT. Miss: go DONE with error flag set, no slave request (writes dropped).
- WAIT: on s_ack[sel], capture s_rdata slice sel into m_rdata register; go DONE. Acks from non-selected slaves ignored.
- DONE: m_stall=0, m_err = error flag, m_rdata = captured data (0 on error or write); unconditionally go IDLE.
- m_stall = (state==IDLE & m_req) | (state==WAIT); 0 in DONE.
- s_ack in IDLE or DONE ignored.
- Reset values: state IDLE, s_req 0, s_addr/s_wstrb/s_wdata 0, m_rdata 0, m_err 0, m_stall follows m_req per formula (combinational).

## Timing
- Hit, slave acks 1 cycle after s_req: m_req rises cycle 0, s_req cycle 1, s_ack cycle 2, DONE cycle 3; stall high cycles 0-2.
- Each extra slave wait cycle adds one stall cycle.
- Miss: stall cycle 0, DONE (m_err=1) cycle 1.
- Ack in the same cycle as s_req is legal and accepted (WAIT entered with s_req high).
- Reset mid-WAIT: IDLE next cycle; late ack from the abandoned slave ignored.
- Back-to-back: new m_req accepted in IDLE the cycle after DONE.

## Configuration
- BUS_TIMEOUT_EN defined: counter cleared on WAIT entry, incremented each WAIT cycle; on reaching TIMEOUT without ack, go DONE with m_err=1, m_rdata=0; a later ack from that slave is ignored.
- Undefined: no counter; WAIT holds indefinitely until ack.

## Structure
- Package bus_pkg: state enum (IDLE, WAIT, DONE), strobe-width constant, default base/mask constants for RAM and MMIO windows.
- Sub-module addr_decoder: combinational priority decode of m_addr to hit flag and index; instantiated once.

## Test plan
- Read slave 0 (base 0x0000_0000, mask 0xFFFF_0000) at 0x0000_0010, ack 1 cycle after s_req, rdata 0x1234_5678 -> stall 3 cycles, m_rdata=0x1234_5678 in DONE, m_err=0.
- Write 0xCAFE_F00D strobe 4'b0011 to slave 2 with 4 wait cycles -> s_wdata/s_wstrb match, stall 6 cycles, m_err=0.
- Access unmapped 0xF000_0000 -> no s_req, DONE on cycle 1 with m_err=1, m_rdata=0.
- Overlapping windows slave 1 and 3 both hit -> s_req=4'b0010 only; spurious s_ack[3] during WAIT ignored.
- Reset asserted in WAIT, slave acks 2 cycles later -> state IDLE, no m_err, m_stall follows m_req.
- BUS_TIMEOUT_EN, TIMEOUT=15, slave never acks -> DONE after 15 WAIT cycles with m_err=1; without macro stall stays high 100 cycles.
